// File: rtl/depkt_pkg.sv
// Shared definitions for the receive-side frame parser: state encoding,
// error codes, default start-of-frame byte and the frame checksum rule.
package depkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
  localparam logic [1:0] ERR_BAD_CSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // LEN + payload + CSUM must wrap to zero; sum already holds LEN + payload.
  function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] csum_byte);
    logic [7:0] total;
    total = sum + csum_byte;
    return (total == 8'd0);
  endfunction

endpackage

// File: rtl/rx_frame_buf.sv
// Payload staging buffer: register array with one synchronous write port and
// one asynchronous read port. Contents are not reset.
module rx_frame_buf #(
  parameter int DEPTH  = 16,
  parameter int AW     = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Address decode by comparison keeps out-of-range pointer values harmless.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we && (waddr == AW'(i))) mem[i] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/depacketizer_fsm.sv
// Receive-side frame parser: hunts for SOF, checks length and checksum, and
// forwards only the payload of good frames to the RX FIFO write port.
module depacketizer_fsm import depkt_pkg::*; #(
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 10000,
  parameter logic [7:0] SOF            = SOF_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       fifo_full,
  output logic       wr_en,
  output logic [7:0] fifo_wdata,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       rx_drop
);

  localparam int PW = $clog2(MAX_LEN + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);

  state_t        state;
  logic [PW-1:0] len;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    sum;
  logic [CW-1:0] tmo_cnt;

  logic          buf_we;
  logic [7:0]    buf_rdata;
  logic [PW-1:0] last_idx;
  logic          in_frame;
  logic          timeout_hit;

  rx_frame_buf #(
    .DEPTH  (MAX_LEN),
    .AW     (PW),
    .DATA_W (8)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_ptr),
    .rdata (buf_rdata)
  );

  assign buf_we     = (state == ST_PAYLOAD) && rx_valid;
  assign wr_en      = (state == ST_DRAIN) && !fifo_full;
  // Gated so the write-data bus sits at zero outside a drain, including reset.
  assign fifo_wdata = (state == ST_DRAIN) ? buf_rdata : 8'd0;
  assign last_idx   = len - PW'(1);
  assign in_frame   = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
  // A byte landing on the limit cycle wins over the timeout.
  assign timeout_hit = in_frame && !rx_valid && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      len        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sum        <= 8'd0;
      tmo_cnt    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
      rx_drop    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      rx_drop    <= 1'b0;

      if (in_frame) tmo_cnt <= rx_valid ? '0 : tmo_cnt + CW'(1);

      if (timeout_hit) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        tmo_cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_valid && (rx_data == SOF)) begin
              state   <= ST_LEN;
              tmo_cnt <= '0;
            end
          end

          ST_LEN: begin
            if (rx_valid) begin
              if ((rx_data == 8'd0) || (rx_data > LEN_MAX)) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
                err_code  <= ERR_BAD_LEN;
              end else begin
                len    <= PW'(rx_data);
                sum    <= rx_data;
                wr_ptr <= '0;
                state  <= ST_PAYLOAD;
              end
            end
          end

          ST_PAYLOAD: begin
            if (rx_valid) begin
              sum    <= sum + rx_data;
              wr_ptr <= wr_ptr + PW'(1);
              if (wr_ptr == last_idx) state <= ST_CSUM;
            end
          end

          ST_CSUM: begin
            if (rx_valid) begin
              if (csum_ok(sum, rx_data)) begin
                rd_ptr <= '0;
                state  <= ST_DRAIN;
              end else begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
                err_code  <= ERR_BAD_CSUM;
              end
            end
          end

          ST_DRAIN: begin
            if (rx_valid) rx_drop <= 1'b1;
            if (wr_en) begin
              rd_ptr <= rd_ptr + PW'(1);
              if (rd_ptr == last_idx) begin
                frame_done <= 1'b1;
                state      <= ST_IDLE;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_depacketizer_fsm.sv
// Bench for depacketizer_fsm: queue-based frame model checked every cycle,
// directed frames with literal expectations, then randomized traffic.
module tb_depacketizer_fsm;

  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 20;
  localparam logic [7:0] SOF     = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       fifo_full = 1'b0;
  logic       wr_en;
  logic [7:0] fifo_wdata;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       rx_drop;

  depacketizer_fsm #(
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TMO),
    .SOF            (SOF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fifo_full  (fifo_full),
    .wr_en      (wr_en),
    .fifo_wdata (fifo_wdata),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .rx_drop    (rx_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit rnd_full = 1'b0;

  // Reference model: bytes of the frame being parsed and payload awaiting the FIFO.
  bit         m_in = 1'b0;
  logic [7:0] m_fr[$];
  logic [7:0] m_dq[$];
  int         m_idle = 0;
  logic       m_done = 1'b0, m_err = 1'b0, m_drop = 1'b0;
  logic [1:0] m_code = 2'd0;
  bit         m_draining;
  logic [7:0] m_sum;

  // Observation logs for the directed literal checks.
  logic [7:0] wlog[$];
  int         wcyc[$];
  int         donecyc[$];
  int         errcnt = 0;
  int         dropcnt = 0;
  int         total_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic merr(input logic [1:0] c);
    m_err  = 1'b1;
    m_code = c;
    m_in   = 1'b0;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_in = 1'b0; m_fr.delete(); m_dq.delete(); m_idle = 0;
      m_done = 1'b0; m_err = 1'b0; m_drop = 1'b0; m_code = 2'd0;
    end else begin
      m_draining = (m_dq.size() != 0);
      m_done = 1'b0; m_err = 1'b0; m_drop = 1'b0;
      if (rx_valid && m_draining) begin
        m_drop = 1'b1;
      end else if (rx_valid && !m_in) begin
        if (rx_data == SOF) begin
          m_in = 1'b1; m_fr.delete(); m_idle = 0;
        end
      end else if (rx_valid) begin
        m_fr.push_back(rx_data);
        m_idle = 0;
        if (m_fr.size() == 1) begin
          if (rx_data == 8'd0 || int'(rx_data) > MAX_LEN) merr(2'd1);
        end else if (m_fr.size() == int'(m_fr[0]) + 2) begin
          m_sum = 8'd0;
          foreach (m_fr[i]) m_sum = m_sum + m_fr[i];
          if (m_sum == 8'd0) begin
            for (int i = 1; i < m_fr.size() - 1; i++) m_dq.push_back(m_fr[i]);
            m_in = 1'b0;
          end else begin
            merr(2'd2);
          end
        end
      end else if (m_in) begin
        m_idle++;
        if (m_idle == TMO) merr(2'd3);
      end
      if (m_draining && !fifo_full) begin
        void'(m_dq.pop_front());
        if (m_dq.size() == 0) m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("wr_en", wr_en, (m_dq.size() != 0) && !fifo_full);
      if ((m_dq.size() != 0) && !fifo_full) chk("fifo_wdata", fifo_wdata, m_dq[0]);
      chk("frame_done", frame_done, m_done);
      chk("frame_err", frame_err, m_err);
      chk("err_code", err_code, m_code);
      chk("rx_drop", rx_drop, m_drop);
      if (wr_en) begin wlog.push_back(fifo_wdata); wcyc.push_back(cyc); end
      if (frame_done) begin donecyc.push_back(cyc); total_done++; end
      if (frame_err) errcnt++;
      if (rx_drop) dropcnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_full) fifo_full = ($urandom_range(0, 2) == 0);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_q(input logic [7:0] bq[$]);
    foreach (bq[i]) send(bq[i], 0);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!m_in && m_dq.size() == 0) break;
      tick();
    end
    chk("wait_idle_busy", (i == budget), 1'b0);
    repeat (2) tick();
  endtask

  task automatic clear_logs();
    wlog.delete(); wcyc.delete(); donecyc.delete();
    errcnt = 0; dropcnt = 0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wr_en"}, wr_en, 1'b0);
    chk({tag, "_fifo_wdata"}, fifo_wdata, 8'd0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_err_code"}, err_code, 2'd0);
    chk({tag, "_rx_drop"}, rx_drop, 1'b0);
  endtask

  function automatic int pick_gap();
    int r;
    r = $urandom_range(0, 39);
    if (r == 0) return TMO - 1;
    if (r == 1) return TMO;
    return $urandom_range(0, 2);
  endfunction

  task automatic rand_frame();
    int kind, len;
    logic [7:0] q[$];
    logic [7:0] b, s8, cs;
    kind = $urandom_range(0, 9);
    q.delete();
    if (kind == 0) begin
      repeat ($urandom_range(1, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == SOF) b = 8'h00;
        q.push_back(b);
      end
    end else if (kind == 1) begin
      q.push_back(SOF);
      q.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
    end else begin
      len = $urandom_range(1, MAX_LEN);
      q.push_back(SOF);
      q.push_back(8'(len));
      s8 = 8'(len);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(0, 255));
        s8 = s8 + b;
        q.push_back(b);
      end
      cs = 8'h00 - s8;
      if (kind == 2) cs = cs + 8'($urandom_range(1, 255));
      q.push_back(cs);
    end
    foreach (q[i]) send(q[i], pick_gap());
    if ($urandom_range(0, 7) != 0) wait_idle(300);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] q[$];

    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Good frame preceded by garbage
    clear_logs();
    q = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h11, 8'h22, 8'hCB};
    send_q(q);
    wait_idle(50);
    chk("good_nwrites", wlog.size(), 2);
    chk("good_w0", wlog[0], 8'h11);
    chk("good_w1", wlog[1], 8'h22);
    chk("good_consecutive", wcyc[1] - wcyc[0], 1);
    chk("good_done_cnt", donecyc.size(), 1);
    chk("good_done_after_last", donecyc[0], wcyc[1] + 1);
    chk("good_errcnt", errcnt, 0);
    chk("good_err_code", err_code, 2'd0);

    // Bad checksum, then a one-byte good frame
    clear_logs();
    q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'hCC};
    send_q(q);
    wait_idle(50);
    chk("badcs_nwrites", wlog.size(), 0);
    chk("badcs_errcnt", errcnt, 1);
    chk("badcs_code", err_code, 2'd2);
    q = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    send_q(q);
    wait_idle(50);
    chk("one_nwrites", wlog.size(), 1);
    chk("one_w0", wlog[0], 8'h7F);
    chk("one_done_cnt", donecyc.size(), 1);

    // Length of zero and length above the maximum
    clear_logs();
    q = '{8'hA5, 8'h00};
    send_q(q);
    wait_idle(20);
    chk("len0_code", err_code, 2'd1);
    chk("len0_errcnt", errcnt, 1);
    q = '{8'hA5, 8'h11};
    send_q(q);
    wait_idle(20);
    chk("len17_code", err_code, 2'd1);
    chk("len17_errcnt", errcnt, 2);
    chk("badlen_nwrites", wlog.size(), 0);

    // Timeout after a partial frame
    clear_logs();
    q = '{8'hA5, 8'h03, 8'h01};
    send_q(q);
    repeat (TMO + 3) tick();
    chk("tmo_errcnt", errcnt, 1);
    chk("tmo_code", err_code, 2'd3);
    chk("tmo_nwrites", wlog.size(), 0);

    // Byte arriving exactly on the limit cycle is accepted
    clear_logs();
    send(8'hA5, 0);
    send(8'h03, 0);
    send(8'h01, TMO - 1);
    send(8'h02, 0);
    send(8'h03, 0);
    send(8'hF7, 0);
    wait_idle(50);
    chk("limit_errcnt", errcnt, 0);
    chk("limit_nwrites", wlog.size(), 3);
    chk("limit_w2", wlog[2], 8'h03);
    chk("limit_code_held", err_code, 2'd3);

    // Backpressure with bytes arriving during the drain
    clear_logs();
    fifo_full = 1'b1;
    q = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
    send_q(q);
    repeat (2) tick();
    send(8'h44, 0);
    tick();
    chk("bp_no_write_while_full", wlog.size(), 0);
    fifo_full = 1'b0;
    send(8'h55, 0);
    wait_idle(50);
    chk("bp_nwrites", wlog.size(), 3);
    chk("bp_w0", wlog[0], 8'h01);
    chk("bp_w1", wlog[1], 8'h02);
    chk("bp_w2", wlog[2], 8'h03);
    chk("bp_drops", dropcnt, 2);
    chk("bp_done_cnt", donecyc.size(), 1);

    // Reset after the first drain write
    clear_logs();
    q = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
    send_q(q);
    for (int i = 0; i < 20 && wlog.size() == 0; i++) tick();
    chk("rst_first_write", wlog.size(), 1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'hCB};
    send_q(q);
    wait_idle(50);
    chk("postrst_nwrites", wlog.size(), 2);
    chk("postrst_w1", wlog[1], 8'h22);
    chk("postrst_done_cnt", donecyc.size(), 1);

    // Randomized traffic with random FIFO backpressure
    total_done = 0;
    rnd_full = 1'b1;
    repeat (150) rand_frame();
    rnd_full = 1'b0;
    fifo_full = 1'b0;
    wait_idle(300);
    chk("rand_some_frames_done", (total_done > 0), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
